// File: rtl/ext_pkg.sv
// Shared definitions for the operand-extension stage: mode encodings,
// occupancy states and the misalignment rule used by the datapath.
package ext_pkg;

  localparam logic [2:0] EXT_ZERO  = 3'b000;
  localparam logic [2:0] EXT_SIGN  = 3'b001;
  localparam logic [2:0] EXT_UPPER = 3'b010;
  localparam logic [2:0] EXT_LB    = 3'b011;
  localparam logic [2:0] EXT_LBU   = 3'b100;
  localparam logic [2:0] EXT_LH    = 3'b101;
  localparam logic [2:0] EXT_LHU   = 3'b110;
  localparam logic [2:0] EXT_LW    = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ext_state_e;

  // Only the low two offset bits matter; wider offsets only pick a lane.
  function automatic logic ext_misaligned(input logic [2:0] mode,
                                          input logic [1:0] off_lo);
    logic mis;
    mis = 1'b0;
    case (mode)
      EXT_LH, EXT_LHU: mis = off_lo[0];
      EXT_LW:          mis = |off_lo;
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ext_align_comb.sv
// Combinational extension datapath: immediate zero/sign/upper extension and
// little-endian load lane selection with sign/zero extension.
module ext_align_comb
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] result,
  output logic              misalign
);

  logic [DATA_W-1:0] lane_data;
  logic [31:0]       upper_word;
  logic              mis;

  always_comb begin
    lane_data  = data >> {off, 3'b000};
    upper_word = 32'(imm) << (32 - IMM_W);
    mis        = ext_misaligned(mode, off[1:0]);
    result     = '0;
    case (mode)
      EXT_ZERO:  result = DATA_W'(imm);
      EXT_SIGN:  result = DATA_W'($signed(imm));
      EXT_UPPER: result = DATA_W'($signed(upper_word));
      EXT_LB:    result = DATA_W'($signed(lane_data[7:0]));
      EXT_LBU:   result = DATA_W'(lane_data[7:0]);
      EXT_LH:    result = DATA_W'($signed(lane_data[15:0]));
      EXT_LHU:   result = DATA_W'(lane_data[15:0]);
      EXT_LW:    result = DATA_W'($signed(lane_data[31:0]));
      default:   result = '0;
    endcase
    // A misaligned access delivers a zero result alongside the flag.
    if (mis) begin
      result = '0;
    end
  end

  assign misalign = mis;

endmodule

// File: rtl/ext_align_stage.sv
// Registered extension stage with a 2-entry skid buffer; in_ready depends only
// on registered state (and flush/reset), never on out_ready.
module ext_align_stage
  import ext_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int IMM_W  = 16,
  parameter  int TAG_W  = 5,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_misalign
);

  logic [DATA_W-1:0] calc_data;
  logic              calc_mis;

  ext_align_comb #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W),
    .OFF_W (OFF_W)
  ) u_comb (
    .mode    (in_mode),
    .imm     (in_imm),
    .data    (in_data),
    .off     (in_off),
    .result  (calc_data),
    .misalign(calc_mis)
  );

  ext_state_e        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_mis_q, out_mis_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
  logic              skid_mis_q, skid_mis_d;
  logic              accept, pop;

  assign in_ready     = in_ready_q & ~flush & ~reset;
  assign out_valid    = (state_q != ST_EMPTY);
  assign out_data     = out_data_q;
  assign out_tag      = out_tag_q;
  assign out_misalign = out_mis_q;
  assign accept       = in_valid & in_ready;
  assign pop          = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_mis_d   = out_mis_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    skid_mis_d  = skid_mis_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_data_d = calc_data;
          out_tag_d  = in_tag;
          out_mis_d  = calc_mis;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          out_data_d = calc_data;
          out_tag_d  = in_tag;
          out_mis_d  = calc_mis;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          skid_data_d = calc_data;
          skid_tag_d  = in_tag;
          skid_mis_d  = calc_mis;
          state_d     = ST_TWO;
        end
      end
      ST_TWO: begin
        if (pop) begin
          out_data_d = skid_data_q;
          out_tag_d  = skid_tag_q;
          out_mis_d  = skid_mis_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops held items; a pop seen this cycle has already completed.
    if (flush) begin
      state_d = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_mis_q   <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_mis_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_mis_q   <= out_mis_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      skid_mis_q  <= skid_mis_d;
    end
  end

endmodule

// File: tb/tb_ext_align_stage.sv
// Self-checking bench for ext_align_stage: 32-bit and 64-bit instances,
// directed examples plus a randomized stream against a queue-based model.
module tb_ext_align_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_mode = '0;
  logic [15:0] in_imm = '0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_off = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_misalign;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [2:0]  w_in_mode = '0;
  logic [15:0] w_in_imm = '0;
  logic [63:0] w_in_data = '0;
  logic [2:0]  w_in_off = '0;
  logic [4:0]  w_in_tag = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_tag;
  logic        w_out_misalign;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ext_align_stage #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_imm(in_imm),
    .in_data(in_data), .in_off(in_off), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_misalign(out_misalign)
  );

  ext_align_stage #(.DATA_W(64), .IMM_W(16), .TAG_W(5)) dut_wide (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_mode(w_in_mode), .in_imm(w_in_imm),
    .in_data(w_in_data), .in_off(w_in_off), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_tag(w_out_tag), .out_misalign(w_out_misalign)
  );

  // Reference: value arithmetic on the operation's meaning (size, signedness, lane).
  function automatic logic [63:0] ref_calc(input int w, input logic [2:0] mode,
                                           input logic [15:0] imm, input logic [63:0] data,
                                           input int off, output logic mis);
    longint          s;
    longint unsigned v;
    int              size;
    bit              sgn;
    logic [63:0]     r;
    mis = 1'b0;
    s = 0;
    case (mode)
      3'd0: s = longint'(imm);
      3'd1: begin
        s = longint'(imm);
        if (imm >= 16'h8000) s = s - 65536;
      end
      3'd2: begin
        s = longint'(imm) * 65536;
        if (s >= 64'sh8000_0000) s = s - 64'sh1_0000_0000;
      end
      default: begin
        size = (mode == 3'd3 || mode == 3'd4) ? 1 : (mode == 3'd5 || mode == 3'd6) ? 2 : 4;
        sgn  = (mode == 3'd3 || mode == 3'd5 || mode == 3'd7);
        if (off % size != 0) begin
          mis = 1'b1;
          s = 0;
        end else begin
          v = (data >> (8 * off)) % (64'd1 << (8 * size));
          s = longint'(v);
          if (sgn && v >= (64'd1 << (8 * size - 1))) s = s - longint'(64'd1 << (8 * size));
        end
      end
    endcase
    r = 64'(s);
    if (w == 32) r[63:32] = '0;
    return r;
  endfunction

  task automatic send32(input logic [2:0] m, input logic [15:0] imm, input logic [31:0] d,
                        input logic [1:0] off, input logic [4:0] tag);
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_imm = imm; in_data = d; in_off = off; in_tag = tag;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send64(input logic [2:0] m, input logic [15:0] imm, input logic [63:0] d,
                        input logic [2:0] off, input logic [4:0] tag);
    @(negedge clk);
    w_in_valid = 1'b1; w_in_mode = m; w_in_imm = imm; w_in_data = d; w_in_off = off;
    w_in_tag = tag; w_out_ready = 1'b1;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
  endtask

  task automatic drain;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; w_in_valid = 1'b0; w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    vectors++; if (out_tag !== 5'h0) begin miscompares++; $display("[TB] FAIL reset_out_tag: got %h expected 0", out_tag); end
    vectors++; if (out_misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_misalign: got %b expected 0", out_misalign); end
    vectors++; if (w_out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wide_valid: got %b expected 0", w_out_valid); end
  endtask

  task automatic test_imm;
    send32(3'b001, 16'h8001, 32'h0, 2'd0, 5'd1);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL latency_valid: got %b expected 1", out_valid); end
    vectors++; if (out_data !== 32'hFFFF8001) begin miscompares++; $display("[TB] FAIL imm_sign: got %h expected FFFF8001", out_data); end
    send32(3'b000, 16'h8001, 32'hFFFFFFFF, 2'd3, 5'd2);
    vectors++; if (out_data !== 32'h00008001) begin miscompares++; $display("[TB] FAIL imm_zero: got %h expected 00008001", out_data); end
    vectors++; if (out_tag !== 5'd2) begin miscompares++; $display("[TB] FAIL imm_tag: got %h expected 02", out_tag); end
    send32(3'b010, 16'h1234, 32'h0, 2'd1, 5'd3);
    vectors++; if (out_data !== 32'h12340000) begin miscompares++; $display("[TB] FAIL imm_upper: got %h expected 12340000", out_data); end
    vectors++; if (out_misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL imm_nomisalign: got %b expected 0", out_misalign); end
  endtask

  task automatic test_load;
    send32(3'b011, 16'h0, 32'h80FF7F01, 2'd1, 5'd4);
    vectors++; if (out_data !== 32'h0000007F) begin miscompares++; $display("[TB] FAIL lb_off1: got %h expected 0000007F", out_data); end
    send32(3'b011, 16'h0, 32'h80FF7F01, 2'd3, 5'd5);
    vectors++; if (out_data !== 32'hFFFFFF80) begin miscompares++; $display("[TB] FAIL lb_off3: got %h expected FFFFFF80", out_data); end
    send32(3'b100, 16'h0, 32'h80FF7F01, 2'd3, 5'd6);
    vectors++; if (out_data !== 32'h00000080) begin miscompares++; $display("[TB] FAIL lbu_off3: got %h expected 00000080", out_data); end
    send32(3'b101, 16'h0, 32'h80FF7F01, 2'd2, 5'd7);
    vectors++; if (out_data !== 32'hFFFF80FF) begin miscompares++; $display("[TB] FAIL lh_off2: got %h expected FFFF80FF", out_data); end
  endtask

  task automatic test_misalign;
    send32(3'b110, 16'h0, 32'h80FF7F01, 2'd1, 5'd8);
    vectors++; if (out_misalign !== 1'b1) begin miscompares++; $display("[TB] FAIL lhu_mis_flag: got %b expected 1", out_misalign); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("[TB] FAIL lhu_mis_data: got %h expected 0", out_data); end
    send32(3'b111, 16'h0, 32'h80FF7F01, 2'd2, 5'd9);
    vectors++; if (out_misalign !== 1'b1) begin miscompares++; $display("[TB] FAIL lw_mis_flag: got %b expected 1", out_misalign); end
    send32(3'b111, 16'h0, 32'h80FF7F01, 2'd0, 5'd10);
    vectors++; if (out_data !== 32'h80FF7F01) begin miscompares++; $display("[TB] FAIL lw_off0: got %h expected 80FF7F01", out_data); end
    vectors++; if (out_misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL lw_off0_flag: got %b expected 0", out_misalign); end
    drain();
  endtask

  task automatic test_wide;
    logic [63:0] exp_d;
    logic        exp_m;
    logic [2:0]  m;
    logic [15:0] imm;
    logic [63:0] d;
    logic [2:0]  off;
    send64(3'b111, 16'h0, 64'h87654321_00000000, 3'd4, 5'd11);
    vectors++; if (w_out_data !== 64'hFFFFFFFF87654321) begin miscompares++; $display("[TB] FAIL wide_lw_off4: got %h expected FFFFFFFF87654321", w_out_data); end
    send64(3'b010, 16'h8000, 64'h0, 3'd0, 5'd12);
    vectors++; if (w_out_data !== 64'hFFFFFFFF80000000) begin miscompares++; $display("[TB] FAIL wide_upper: got %h expected FFFFFFFF80000000", w_out_data); end
    for (int i = 0; i < 24; i++) begin
      m = 3'($urandom_range(0, 7));
      imm = 16'($urandom);
      d = {32'($urandom), 32'($urandom)};
      off = 3'($urandom_range(0, 7));
      send64(m, imm, d, off, 5'(i));
      exp_d = ref_calc(64, m, imm, d, int'(off), exp_m);
      vectors++; if (w_out_data !== exp_d || w_out_misalign !== exp_m) begin miscompares++; $display("[TB] FAIL wide_random mode=%0d off=%0d: got %h/%b expected %h/%b", m, off, w_out_data, w_out_misalign, exp_d, exp_m); end
    end
    drain();
  endtask

  task automatic test_random_stream;
    exp_t        e;
    logic [63:0] r;
    logic        m;
    bit          acc, pp;
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge clk);
      in_valid  = (cyc < 260) && ($urandom_range(0, 3) != 0);
      out_ready = (cyc >= 260) || ($urandom_range(0, 2) != 0);
      in_mode   = 3'($urandom_range(0, 7));
      in_imm    = 16'($urandom);
      in_data   = 32'($urandom);
      in_off    = 2'($urandom_range(0, 3));
      in_tag    = 5'($urandom);
      #1;
      vectors++; if (out_valid !== (sb.size() != 0)) begin miscompares++; $display("[TB] FAIL stream_valid cyc=%0d: got %b expected %b", cyc, out_valid, sb.size() != 0); end
      vectors++; if (in_ready !== (sb.size() < 2)) begin miscompares++; $display("[TB] FAIL stream_ready cyc=%0d: got %b expected %b", cyc, in_ready, sb.size() < 2); end
      acc = in_valid && (sb.size() < 2);
      pp  = out_ready && (sb.size() != 0);
      if (pp) begin
        e = sb.pop_front();
        vectors++; if (out_data !== e.data || out_tag !== e.tag || out_misalign !== e.mis) begin miscompares++; $display("[TB] FAIL stream_item cyc=%0d: got %h/%h/%b expected %h/%h/%b", cyc, out_data, out_tag, out_misalign, e.data, e.tag, e.mis); end
      end
      if (acc) begin
        r = ref_calc(32, in_mode, in_imm, {32'h0, in_data}, int'(in_off), m);
        e.data = r[31:0];
        e.tag  = in_tag;
        e.mis  = m;
        sb.push_back(e);
      end
    end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL stream_leftover: got %0d items expected 0", sb.size()); end
    sb.delete();
    drain();
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int got = 0;
    int cnt = 0;
    bit acc, pp;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid  = (sent < 8);
      in_mode   = 3'b001;
      in_imm    = 16'(sent + 1);
      in_tag    = 5'(sent + 1);
      #1;
      vectors++; if (in_ready !== (cnt < 2)) begin miscompares++; $display("[TB] FAIL b2b_ready cyc=%0d: got %b expected %b", cyc, in_ready, cnt < 2); end
      vectors++; if (out_valid !== (cnt > 0)) begin miscompares++; $display("[TB] FAIL b2b_valid cyc=%0d: got %b expected %b", cyc, out_valid, cnt > 0); end
      acc = in_valid && (cnt < 2);
      pp  = out_ready && (cnt > 0);
      if (pp) begin
        vectors++; if (out_tag !== 5'(got + 1)) begin miscompares++; $display("[TB] FAIL b2b_order: got tag %0d expected %0d", out_tag, got + 1); end
        got++;
      end
      if (acc) sent++;
      cnt = cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
    end
    vectors++; if (got != 8) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected 8", got); end
    drain();
  endtask

  task automatic fill_two(input logic [2:0] m, input logic [1:0] off, input logic [4:0] t0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = m; in_imm = 16'h00A5;
    in_data = 32'hCAFE1234; in_off = off; in_tag = t0;
    @(negedge clk);
    in_tag = t0 + 5'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush;
    fill_two(3'b001, 2'd0, 5'd20);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_pre_two: got %b expected 0", in_ready); end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_tag = 5'd22;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_ready_low: got %b expected 0", in_ready); end
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_valid: got %b expected 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_ghost: got valid tag %0d expected none", out_tag); end
    end
  endtask

  task automatic test_reset_mid_stall;
    fill_two(3'b111, 2'd2, 5'd9);
    vectors++; if (out_misalign !== 1'b1 || out_tag !== 5'd9) begin miscompares++; $display("[TB] FAIL stall_pre: got %b/%h expected 1/09", out_misalign, out_tag); end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; out_ready = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst2_valid: got %b expected 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst2_ready: got %b expected 1", in_ready); end
    vectors++; if (out_tag !== 5'h0 || out_misalign !== 1'b0 || out_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst2_regs: got %h/%b/%h expected 0/0/0", out_tag, out_misalign, out_data); end
    @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst2_ghost: got %b expected 0", out_valid); end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_imm();
    test_load();
    test_misalign();
    test_wide();
    test_random_stream();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
